// File: rtl/instr_fetch_unit_if.sv
// Instruction memory fetch bus: registered request with byte address, data returned with a one-cycle ack.
interface instr_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one instruction per advance over the imem bus,
// exposes the decoded fields and computes sequential / BEQ / J next PC.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_fetch_unit_if.master   imem,
    input  logic                 advance_i,
    input  logic                 zero_i,
    output logic [31:0]          pc_o,
    output logic [31:0]          instr_o,
    output logic                 instr_valid_o,
    output logic [5:0]           op_o,
    output logic [5:0]           funct_o,
    output logic [4:0]           rs_o,
    output logic [4:0]           rt_o,
    output logic [4:0]           rd_o,
    output logic [15:0]          imm_o,
    output logic [CNT_WIDTH-1:0] retired_o
);

    typedef enum logic {S_FETCH, S_VALID} state_t;

    state_t               state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic [31:0]          instr_q, instr_d;
    logic                 valid_q, valid_d;
    logic                 req_q, req_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;

    logic [31:0] pc_plus4;
    logic [31:0] branch_off;
    logic [31:0] next_pc;

    always_comb begin
        pc_plus4   = pc_q + 32'd4;
        branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        case (instr_q[31:26])
            6'b000010: next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
            6'b000100: next_pc = zero_i ? (pc_plus4 + branch_off) : pc_plus4;
            default:   next_pc = pc_plus4;
        endcase
    end

    // req is only raised one edge after entering S_FETCH, so an ack left over from
    // an abandoned transaction can never be captured on the first edge.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        req_d     = req_q;
        retired_d = retired_q;
        case (state_q)
            S_FETCH: begin
                if (req_q && imem.ack) begin
                    instr_d = imem.rdata;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = S_VALID;
                end else begin
                    req_d = 1'b1;
                end
            end
            S_VALID: begin
                req_d = 1'b0;
                if (advance_i) begin
                    valid_d   = 1'b0;
                    retired_d = retired_q + CNT_WIDTH'(1);
                    pc_d      = next_pc;
                    state_d   = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            valid_q   <= 1'b0;
            req_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            req_q     <= req_d;
            retired_q <= retired_d;
        end
    end

    assign imem.req      = req_q;
    assign imem.addr     = pc_q;
    assign pc_o          = pc_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    assign op_o          = instr_q[31:26];
    assign funct_o       = instr_q[5:0];
    assign rs_o          = instr_q[25:21];
    assign rt_o          = instr_q[20:16];
    assign rd_o          = instr_q[15:11];
    assign imm_o         = instr_q[15:0];
    assign retired_o     = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus randomized bench for instr_fetch_unit, checked against a transaction-level
// model that tracks the expected PC, held instruction and retired count.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        advance;
    logic        zero;
    logic [31:0] pc, instr;
    logic        instrValid;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] retired;

    instr_fetch_unit_if ifc ();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (ifc),
        .advance_i     (advance),
        .zero_i        (zero),
        .pc_o          (pc),
        .instr_o       (instr),
        .instr_valid_o (instrValid),
        .op_o          (op),
        .funct_o       (funct),
        .rs_o          (rs),
        .rt_o          (rt),
        .rd_o          (rd),
        .imm_o         (imm),
        .retired_o     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] expPc;
    logic [31:0] expRetired;
    logic [31:0] curWord;

    // Architectural next-PC rule evaluated with plain integer arithmetic.
    function automatic logic [31:0] refNextPc(input logic [31:0] curPc, input logic [31:0] word,
                                              input logic z);
        logic [31:0] p4;
        int          off;
        int unsigned opcode;
        p4     = curPc + 32'd4;
        opcode = word >> 26;
        off    = $signed(word[15:0]);
        if (opcode == 2)
            return (p4 & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 4);
        else if (opcode == 4 && z)
            return p4 + 32'(off * 4);
        return p4;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkHeld(input string tag);
        checkOutput({tag, ".valid"}, instrValid, 1'b1);
        checkOutput({tag, ".req"}, ifc.req, 1'b0);
        checkOutput({tag, ".instr"}, instr, curWord);
        checkOutput({tag, ".op"}, op, curWord >> 26);
        checkOutput({tag, ".rs"}, rs, (curWord >> 21) & 32'h1F);
        checkOutput({tag, ".rt"}, rt, (curWord >> 16) & 32'h1F);
        checkOutput({tag, ".rd"}, rd, (curWord >> 11) & 32'h1F);
        checkOutput({tag, ".imm"}, imm, curWord & 32'hFFFF);
        checkOutput({tag, ".funct"}, funct, curWord & 32'h3F);
    endtask

    // Request already high: wait `delay` cycles (optionally poking advance), then ack.
    task automatic fetchAccept(input logic [31:0] word, input int delay, input bit pokeAdvance);
        for (int i = 0; i < delay; i++) begin
            advance = pokeAdvance && (i == 1);
            ifc.rdata = $urandom;
            tick();
            advance = 1'b0;
            checkOutput("wait.req", ifc.req, 1'b1);
            checkOutput("wait.addr", ifc.addr, expPc);
            checkOutput("wait.valid", instrValid, 1'b0);
            checkOutput("wait.retired", retired, expRetired);
        end
        ifc.ack   = 1'b1;
        ifc.rdata = word;
        tick();
        ifc.ack   = 1'b0;
        ifc.rdata = $urandom;
        curWord   = word;
        checkHeld("accept");
        checkOutput("accept.pc", pc, expPc);
    endtask

    // Entry point right after reset release or an advance: req rises on the next edge.
    task automatic applyStimulus(input logic [31:0] word, input int delay, input bit pokeAdvance);
        tick();
        checkOutput("reqRise", ifc.req, 1'b1);
        checkOutput("reqAddr", ifc.addr, expPc);
        checkOutput("reqValid", instrValid, 1'b0);
        fetchAccept(word, delay, pokeAdvance);
    endtask

    task automatic advanceInstr(input logic z);
        advance = 1'b1;
        zero    = z;
        tick();
        advance = 1'b0;
        zero    = $urandom_range(0, 1);
        expPc      = refNextPc(expPc, curWord, z);
        expRetired = expRetired + 1;
        checkOutput("adv.pc", pc, expPc);
        checkOutput("adv.addr", ifc.addr, expPc);
        checkOutput("adv.retired", retired, expRetired);
        checkOutput("adv.valid", instrValid, 1'b0);
        checkOutput("adv.req", ifc.req, 1'b0);
    endtask

    task automatic idleValid(input int n);
        for (int i = 0; i < n; i++) begin
            ifc.ack   = 1'b1;
            ifc.rdata = $urandom;
            tick();
            ifc.ack = 1'b0;
            checkHeld("idle");
        end
    endtask

    initial begin
        rst       = 1'b1;
        advance   = 1'b0;
        zero      = 1'b0;
        ifc.ack   = 1'b0;
        ifc.rdata = 32'd0;
        expPc      = 32'd0;
        expRetired = 32'd0;
        curWord    = 32'd0;
        repeat (2) tick();
        checkOutput("rst.pc", pc, 32'd0);
        checkOutput("rst.instr", instr, 32'd0);
        checkOutput("rst.valid", instrValid, 1'b0);
        checkOutput("rst.req", ifc.req, 1'b0);
        checkOutput("rst.retired", retired, 32'd0);
        rst = 1'b0;

        // ADDI at 0 acked in the first request cycle, then sequential advance.
        applyStimulus(32'h2008_0005, 0, 1'b0);
        checkOutput("addi.op", op, 6'b001000);
        checkOutput("addi.rt", rt, 5'd8);
        checkOutput("addi.imm", imm, 16'd5);
        advanceInstr(1'b0);
        checkOutput("addi.nextpc", pc, 32'd4);
        applyStimulus(32'h0000_0020, 1, 1'b0);
        advanceInstr(1'b1);
        // BEQ not taken at 8, J back to 8, BEQ taken to 24, J to 0x40.
        applyStimulus(32'h1000_0003, 0, 1'b0);
        advanceInstr(1'b0);
        checkOutput("beq.nt", pc, 32'd12);
        applyStimulus(32'h0800_0002, 0, 1'b0);
        advanceInstr(1'b1);
        checkOutput("j.back", pc, 32'd8);
        applyStimulus(32'h1000_0003, 0, 1'b0);
        advanceInstr(1'b1);
        checkOutput("beq.t", pc, 32'd24);
        applyStimulus(32'h0800_0010, 0, 1'b0);
        advanceInstr(1'b0);
        checkOutput("j.abs", pc, 32'h40);
        // Branch to self, and a 5-cycle ack delay with a stray advance.
        applyStimulus(32'h1000_FFFF, 5, 1'b1);
        advanceInstr(1'b1);
        checkOutput("beq.self", pc, 32'h40);
        // Wrap: BEQ -2 words from 0 lands on 0xFFFF_FFFC, then +4 wraps to 0.
        applyStimulus(32'h0800_0000, 0, 1'b0);
        advanceInstr(1'b0);
        applyStimulus(32'h1000_FFFE, 0, 1'b0);
        idleValid(2);
        advanceInstr(1'b1);
        checkOutput("wrap.top", pc, 32'hFFFF_FFFC);
        applyStimulus(32'h2008_0001, 0, 1'b0);
        advanceInstr(1'b1);
        checkOutput("wrap.zero", pc, 32'd0);

        // Reset while requesting, with an ack overlapping and outlasting reset.
        applyStimulus(32'h0000_0000, 0, 1'b0);
        advanceInstr(1'b0);
        tick();
        #2 rst = 1'b1;
        #1;
        expPc      = 32'd0;
        expRetired = 32'd0;
        curWord    = 32'd0;
        checkOutput("midrst.pc", pc, 32'd0);
        checkOutput("midrst.valid", instrValid, 1'b0);
        checkOutput("midrst.req", ifc.req, 1'b0);
        checkOutput("midrst.retired", retired, 32'd0);
        ifc.ack   = 1'b1;
        ifc.rdata = 32'hDEAD_BEEF;
        repeat (2) tick();
        checkOutput("midrst.instr", instr, 32'd0);
        rst = 1'b0;
        tick();
        ifc.ack = 1'b0;
        checkOutput("late.req", ifc.req, 1'b1);
        checkOutput("late.valid", instrValid, 1'b0);
        checkOutput("late.instr", instr, 32'd0);
        fetchAccept(32'h2008_0005, 0, 1'b0);
        advanceInstr(1'b0);

        // Randomized instruction mix against the reference model.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] word;
            case ($urandom_range(0, 3))
                0:       word = {6'b000010, 26'($urandom)};
                1:       word = {6'b000100, 26'($urandom)};
                2:       word = {6'b001000, 26'($urandom)};
                default: word = {6'b000000, 26'($urandom)};
            endcase
            applyStimulus(word, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            idleValid($urandom_range(0, 2));
            advanceInstr(1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
